// File: rtl/pipelined_adder.sv
// Pipelined WIDTH-bit add/subtract with one carry chunk per stage and a valid/ready handshake.
// Define ADDER_SATURATE_EN to add the sat input, which clamps the result on signed overflow.
module pipelined_adder #(
    parameter int WIDTH  = 64,
    parameter int STAGES = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             Cin,
    input  logic             sub,
`ifdef ADDER_SATURATE_EN
    input  logic             sat,
`endif
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             Cout,
    output logic             overflow,
    output logic             zero,
    output logic             negative
);
    localparam int CHUNK = WIDTH / STAGES;

    logic              adv;
    logic [STAGES:0]   vld_pipe;
    logic [WIDTH-1:0]  a_in [STAGES];
    logic [WIDTH-1:0]  b_in [STAGES];
    logic [WIDTH-1:0]  r_in [STAGES];
    logic              c_in [STAGES];
    logic              s_in [STAGES];

    // One global stall: the whole pipe moves only when the output slot frees up.
    assign adv         = out_ready | ~out_valid;
    assign in_ready    = adv;
    assign vld_pipe[0] = in_valid;
    assign out_valid   = vld_pipe[STAGES];

    assign a_in[0] = A;
    assign b_in[0] = sub ? ~B : B;
    assign r_in[0] = '0;
    assign c_in[0] = sub | Cin;
`ifdef ADDER_SATURATE_EN
    assign s_in[0] = sat;
`else
    assign s_in[0] = 1'b0;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            vld_pipe[STAGES:1] <= '0;
        else if (adv)
            vld_pipe[STAGES:1] <= vld_pipe[STAGES-1:0];
    end

    for (genvar s = 0; s < STAGES; s++) begin : g_stage
        logic [CHUNK:0]   csum;
        logic [WIDTH-1:0] r_nx;

        assign csum = {1'b0, a_in[s][s*CHUNK +: CHUNK]}
                    + {1'b0, b_in[s][s*CHUNK +: CHUNK]}
                    + {{CHUNK{1'b0}}, c_in[s]};

        always_comb begin
            r_nx = r_in[s];
            r_nx[s*CHUNK +: CHUNK] = csum[CHUNK-1:0];
        end

        if (s < STAGES-1) begin : g_mid
            logic [WIDTH-1:0] a_q, b_q, r_q;
            logic             c_q, s_q;

            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    a_q <= '0;
                    b_q <= '0;
                    r_q <= '0;
                    c_q <= 1'b0;
                    s_q <= 1'b0;
                end else if (adv) begin
                    a_q <= a_in[s];
                    b_q <= b_in[s];
                    r_q <= r_nx;
                    c_q <= csum[CHUNK];
                    s_q <= s_in[s];
                end
            end

            assign a_in[s+1] = a_q;
            assign b_in[s+1] = b_q;
            assign r_in[s+1] = r_q;
            assign c_in[s+1] = c_q;
            assign s_in[s+1] = s_q;
        end else begin : g_last
            logic             cmsb, ovf;
            logic [WIDTH-1:0] res;

            // Carry into the MSB recovered from the MSB sum bit; also valid when CHUNK == 1.
            assign cmsb = csum[CHUNK-1] ^ a_in[s][WIDTH-1] ^ b_in[s][WIDTH-1];
            assign ovf  = cmsb ^ csum[CHUNK];

            always_comb begin
                res = r_nx;
                if (s_in[s] && ovf)
                    res = a_in[s][WIDTH-1] ? {1'b1, {(WIDTH-1){1'b0}}}
                                           : {1'b0, {(WIDTH-1){1'b1}}};
            end

            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    result   <= '0;
                    Cout     <= 1'b0;
                    overflow <= 1'b0;
                    zero     <= 1'b0;
                    negative <= 1'b0;
                end else if (adv) begin
                    result   <= res;
                    Cout     <= csum[CHUNK];
                    overflow <= ovf;
                    zero     <= (res == '0);
                    negative <= res[WIDTH-1];
                end
            end
        end
    end
endmodule

// File: tb/tb_pipelined_adder.sv
// Self-checking bench for pipelined_adder at WIDTH=8, STAGES=2: vector table, corner sequences, random scoreboard.
module tb_pipelined_adder;
    localparam int W = 8;
    localparam int S = 2;

    logic         clk;
    logic         reset, in_valid, in_ready, Cin, sub, sat_i;
    logic [W-1:0] A, B, result;
    logic         out_valid, out_ready, Cout, overflow, zero, negative;

    pipelined_adder #(.WIDTH(W), .STAGES(S)) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .A(A), .B(B), .Cin(Cin), .sub(sub),
`ifdef ADDER_SATURATE_EN
        .sat(sat_i),
`endif
        .out_valid(out_valid), .out_ready(out_ready), .result(result),
        .Cout(Cout), .overflow(overflow), .zero(zero), .negative(negative)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [W-1:0] res;
        logic         cout, ov, zero, neg;
    } exp_t;

    typedef struct {
        logic [W-1:0] a, b;
        logic         cin, sub, sat;
        exp_t         e;
    } vec_t;

    int checks = 0;
    int errs   = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
        end
    endtask

    task automatic chk_out(input string nm, input exp_t e);
        chk({nm, ".result"},   32'(result),   32'(e.res));
        chk({nm, ".cout"},     32'(Cout),     32'(e.cout));
        chk({nm, ".overflow"}, 32'(overflow), 32'(e.ov));
        chk({nm, ".zero"},     32'(zero),     32'(e.zero));
        chk({nm, ".negative"}, 32'(negative), 32'(e.neg));
    endtask

    // Reference: plain integer arithmetic, signed overflow judged by range.
    function automatic exp_t model(input logic [W-1:0] a, b, input logic cin, sb, st);
        exp_t e;
        int full, sres;
        if (sb) begin
            full = int'(a) - int'(b) + 256;
            sres = int'($signed(a)) - int'($signed(b));
        end else begin
            full = int'(a) + int'(b) + int'(cin);
            sres = int'($signed(a)) + int'($signed(b)) + int'(cin);
        end
        e.cout = (full >= 256);
        e.res  = 8'(full);
        e.ov   = (sres > 127) || (sres < -128);
        if (st && e.ov) e.res = (sres > 127) ? 8'h7F : 8'h80;
        e.zero = (e.res == 8'h00);
        e.neg  = e.res[W-1];
        return e;
    endfunction

    function automatic vec_t mk(input logic [W-1:0] a, b, input logic cin, sb, st,
                                input logic [W-1:0] r, input logic co, ov, z, n);
        vec_t v;
        v.a = a; v.b = b; v.cin = cin; v.sub = sb; v.sat = st;
        v.e.res = r; v.e.cout = co; v.e.ov = ov; v.e.zero = z; v.e.neg = n;
        return v;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [W-1:0] a, b, input logic cin, sb, st, v);
        A = a; B = b; Cin = cin; sub = sb; sat_i = st; in_valid = v;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        vec_t tbl[$];
        exp_t q[$];
        int   lat, got, j, last, extra;
        logic prev_stall;
        logic [31:0] snap;

        reset = 1'b1; out_ready = 1'b1;
        drive(8'h00, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
        #2;
        chk("rst.out_valid", 32'(out_valid), 0);
        chk("rst.in_ready",  32'(in_ready),  1);
        chk("rst.flags", {result, Cout, overflow, zero, negative}, 0);
        tick(); tick();
        reset = 1'b0;
        tick();

        tbl.push_back(mk(8'h7F, 8'h01, 0, 0, 0, 8'h80, 0, 1, 0, 1));
        tbl.push_back(mk(8'hFF, 8'h01, 0, 0, 0, 8'h00, 1, 0, 1, 0));
        tbl.push_back(mk(8'hFF, 8'h00, 1, 0, 0, 8'h00, 1, 0, 1, 0));
        tbl.push_back(mk(8'h05, 8'h07, 1, 1, 0, 8'hFE, 0, 0, 0, 1));
        tbl.push_back(mk(8'h80, 8'h01, 0, 1, 0, 8'h7F, 1, 1, 0, 0));
        tbl.push_back(mk(8'h00, 8'h00, 0, 1, 0, 8'h00, 1, 0, 1, 0));
        tbl.push_back(mk(8'h80, 8'h80, 0, 0, 0, 8'h00, 1, 1, 1, 0));
        tbl.push_back(mk(8'h3C, 8'h41, 1, 0, 0, 8'h7E, 0, 0, 0, 0));
`ifdef ADDER_SATURATE_EN
        tbl.push_back(mk(8'h7F, 8'h01, 0, 0, 1, 8'h7F, 0, 1, 0, 0));
        tbl.push_back(mk(8'h80, 8'h01, 0, 1, 1, 8'h80, 1, 1, 0, 1));
        tbl.push_back(mk(8'h7F, 8'h01, 0, 0, 0, 8'h80, 0, 1, 0, 1));
`endif

        foreach (tbl[i]) begin
            drive(tbl[i].a, tbl[i].b, tbl[i].cin, tbl[i].sub, tbl[i].sat, 1'b1);
            tick();
            in_valid = 1'b0;
            lat = 1;
            while (!out_valid && lat < 10) begin
                tick();
                lat++;
            end
            chk($sformatf("vec%0d.latency", i), lat, S);
            chk_out($sformatf("vec%0d", i), tbl[i].e);
        end
        tick();
        chk("drain.out_valid", 32'(out_valid), 0);

        // Back-pressure: four beats against a stalled sink, released after five cycles.
        j = 0; got = 0; last = -1;
        for (int cyc = 0; cyc < 30 && got < 4; cyc++) begin
            out_ready = (cyc >= 5);
            drive(8'(j + 16), 8'(j), 1'b0, 1'b0, 1'b0, j < 4);
            #1;
            if (cyc == 2) chk("bp.in_ready_low", 32'(in_ready), 0);
            if (cyc == 4) chk("bp.hold", {out_valid, result}, {1'b1, 8'h10});
            if (out_valid && out_ready) begin
                chk($sformatf("bp.res%0d", got), 32'(result), 32'(16 + 2 * got));
                if (got > 0) chk($sformatf("bp.gap%0d", got), cyc, last + 1);
                last = cyc;
                got++;
            end
            if (in_valid && in_ready) j++;
            tick();
        end
        chk("bp.count", got, 4);
        in_valid = 1'b0;
        extra = 0;
        repeat (4) begin
            if (out_valid) extra++;
            tick();
        end
        chk("bp.no_dup", extra, 0);

        // Reset with two beats in flight.
        out_ready = 1'b1;
        drive(8'h01, 8'h02, 1'b0, 1'b0, 1'b0, 1'b1); tick();
        drive(8'h03, 8'h03, 1'b0, 1'b0, 1'b0, 1'b1); tick();
        in_valid = 1'b0;
        chk("mid.pre_valid", 32'(out_valid), 1);
        #1 reset = 1'b1;
        #1;
        chk("mid.out_valid", 32'(out_valid), 0);
        chk("mid.in_ready",  32'(in_ready),  1);
        chk("mid.flags", {result, Cout, overflow, zero, negative}, 0);
        tick(); tick();
        reset = 1'b0;
        tick();
        chk("mid.after_valid", 32'(out_valid), 0);
        drive(8'h03, 8'h04, 1'b0, 1'b0, 1'b0, 1'b1);
        tick();
        in_valid = 1'b0;
        lat = 1;
        while (!out_valid && lat < 10) begin
            tick();
            lat++;
        end
        chk("mid.latency", lat, S);
        chk("mid.result", 32'(result), 8'h07);
        tick();
        extra = 0;
        repeat (4) begin
            if (out_valid) extra++;
            tick();
        end
        chk("mid.no_stale", extra, 0);

        // Random stream with random back-pressure against the scoreboard.
        prev_stall = 1'b0; snap = 0;
        for (int cyc = 0; cyc < 400; cyc++) begin
            if (prev_stall)
                chk("rnd.stall_hold", {out_valid, result, Cout, overflow, zero, negative}, snap);
            A = 8'($urandom); B = 8'($urandom);
            Cin = 1'($urandom); sub = 1'($urandom);
`ifdef ADDER_SATURATE_EN
            sat_i = 1'($urandom);
`else
            sat_i = 1'b0;
`endif
            in_valid  = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 2) != 0);
            #1;
            if (q.size() == 0) chk("rnd.idle_valid", 32'(out_valid), 0);
            else if (out_valid && out_ready) chk_out("rnd", q.pop_front());
            if (in_valid && in_ready) q.push_back(model(A, B, Cin, sub, sat_i));
            prev_stall = out_valid && !out_ready;
            snap = {out_valid, result, Cout, overflow, zero, negative};
            tick();
        end
        in_valid = 1'b0; out_ready = 1'b1;
        for (int k = 0; k < 10 && q.size() > 0; k++) begin
            #1;
            if (out_valid) chk_out("drain", q.pop_front());
            tick();
        end
        chk("rnd.queue_empty", q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, errs);
        $finish;
    end
endmodule
